// File: rtl/multi_channel_timestamper.sv
// multi_channel_timestamper: timestamps per-channel triggers against a UTC/coarse time base, RR-arbitrated into a shared FWFT FIFO
module multi_channel_timestamper #(
  parameter int g_num_channels = 4,
  parameter int g_frac_bits = 12,
  parameter int g_coarse_max = 125000000,
  parameter int g_utc_bits = 32,
  parameter int g_fifo_depth = 16
) (
  input  logic clk_ref_i,
  input  logic rst_i,
  input  logic [g_num_channels-1:0] enable_i,
  input  logic [g_num_channels-1:0] trig_p_i,
  input  logic [g_num_channels*g_frac_bits-1:0] frac_i,
  input  logic utc_load_i,
  input  logic [g_utc_bits-1:0] utc_value_i,
  input  logic ovf_clr_i,
  output logic tag_valid_o,
  input  logic tag_ready_i,
  output logic [2:0] tag_channel_o,
  output logic [g_utc_bits-1:0] tag_utc_o,
  output logic [27:0] tag_coarse_o,
  output logic [g_frac_bits-1:0] tag_frac_o,
  output logic [$clog2(g_fifo_depth):0] fifo_level_o,
  output logic [g_num_channels-1:0] overflow_o,
  output logic [g_utc_bits-1:0] cntr_utc_o,
  output logic [27:0] cntr_coarse_o
);
  localparam int N = g_num_channels;
  localparam int FB = g_frac_bits;
  localparam int UB = g_utc_bits;
  localparam int AW = $clog2(g_fifo_depth);
  localparam int LW = AW + 1;
  localparam int TW = UB + 28 + FB;
  localparam int FW = 3 + TW;
  logic [27:0] coarse;
  logic [UB-1:0] utc;
  logic [N-1:0] stg_v, gnt, cap, ovf, ovf_set;
  logic [TW-1:0] stg_tag [N];
  logic [7:0] stg_v8;
  logic [2:0] rr, gnt_idx;
  logic [3:0] idx;
  logic found, gnt_any, pop, full, space, valid;
  logic [TW-1:0] push_tag;
  logic [LW-1:0] level;
  logic [AW-1:0] wp, rp;
  logic [FW-1:0] mem [g_fifo_depth];
  logic [FW-1:0] head;
  always_ff @(posedge clk_ref_i)
    if (rst_i) begin
      coarse <= '0;
      utc <= '0;
    end else if (utc_load_i) begin
      utc <= utc_value_i;
      coarse <= '0;
    end else if (coarse == 28'(g_coarse_max - 1)) begin
      coarse <= '0;
      utc <= utc + UB'(1);
    end else
      coarse <= coarse + 28'd1;
  assign valid = level != '0;
  assign full = level == LW'(g_fifo_depth);
  assign pop = valid & tag_ready_i;
  assign space = !full | pop;
  assign stg_v8 = 8'(stg_v);
  always_comb begin
    found = 1'b0;
    gnt_idx = rr;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = {1'b0, rr} + 4'(k);
      idx = (idx >= 4'(N)) ? idx - 4'(N) : idx;
      if (stg_v8[idx[2:0]]) begin
        found = 1'b1;
        gnt_idx = idx[2:0];
      end
    end
    gnt_any = found & space;
  end
  assign gnt = gnt_any ? N'(1) << gnt_idx : '0;
  always_comb begin
    push_tag = '0;
    for (int c = 0; c < N; c++)
      if (gnt[c]) push_tag = stg_tag[c];
  end
  assign cap = trig_p_i & enable_i & (~stg_v | gnt);
  assign ovf_set = trig_p_i & enable_i & stg_v & ~gnt;
  always_ff @(posedge clk_ref_i)
    if (rst_i) begin
      stg_v <= '0;
      ovf <= '0;
      rr <= 3'(N - 1);
    end else begin
      if (gnt_any) rr <= gnt_idx;
      ovf <= (ovf & {N{!ovf_clr_i}}) | ovf_set;
      for (int c = 0; c < N; c++)
        if (cap[c]) stg_v[c] <= 1'b1;
        else if (gnt[c]) stg_v[c] <= 1'b0;
    end
  always_ff @(posedge clk_ref_i)
    for (int c = 0; c < N; c++)
      if (cap[c]) stg_tag[c] <= {utc, coarse, frac_i[c*FB +: FB]};
  always_ff @(posedge clk_ref_i)
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (gnt_any) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      level <= level + LW'(gnt_any) - LW'(pop);
    end
  always_ff @(posedge clk_ref_i)
    if (gnt_any) mem[wp] <= {gnt_idx, push_tag};
  assign head = valid ? mem[rp] : '0;
  assign tag_valid_o = valid;
  assign tag_channel_o = head[FW-1 -: 3];
  assign tag_utc_o = head[TW-1 -: UB];
  assign tag_coarse_o = head[FB+27 -: 28];
  assign tag_frac_o = head[FB-1:0];
  assign fifo_level_o = level;
  assign overflow_o = ovf;
  assign cntr_utc_o = utc;
  assign cntr_coarse_o = coarse;
endmodule

// File: tb/tb_multi_channel_timestamper.sv
// tb_multi_channel_timestamper: directed self-checking bench for multi_channel_timestamper
module tb_multi_channel_timestamper;
  localparam int N = 4;
  localparam int FB = 12;
  localparam int UB = 32;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] enable, trig, overflow;
  logic [N*FB-1:0] frac;
  logic utc_load, ovf_clr, tag_valid, tag_ready;
  logic [UB-1:0] utc_value, tag_utc, cntr_utc;
  logic [2:0] tag_channel;
  logic [27:0] tag_coarse, cntr_coarse;
  logic [FB-1:0] tag_frac;
  logic [4:0] fifo_level;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  multi_channel_timestamper #(
    .g_num_channels(N), .g_frac_bits(FB), .g_coarse_max(1000), .g_utc_bits(UB), .g_fifo_depth(16)
  ) dut (
    .clk_ref_i(clk), .rst_i(rst), .enable_i(enable), .trig_p_i(trig), .frac_i(frac),
    .utc_load_i(utc_load), .utc_value_i(utc_value), .ovf_clr_i(ovf_clr),
    .tag_valid_o(tag_valid), .tag_ready_i(tag_ready), .tag_channel_o(tag_channel),
    .tag_utc_o(tag_utc), .tag_coarse_o(tag_coarse), .tag_frac_o(tag_frac),
    .fifo_level_o(fifo_level), .overflow_o(overflow), .cntr_utc_o(cntr_utc), .cntr_coarse_o(cntr_coarse)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_coarse(input int v);
    int n;
    n = 0;
    while (cntr_coarse != 28'(v) && n < 2100) begin
      tick();
      n++;
    end
    chk("wait_coarse", 64'(cntr_coarse), 64'(v));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; enable = 4'hF; trig = '0; frac = '0; utc_load = 1'b0; utc_value = '0;
    ovf_clr = 1'b0; tag_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", 64'(tag_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_coarse", 64'(cntr_coarse), 64'd0);
    chk("rst_utc", 64'(cntr_utc), 64'd0);
    chk("rst_tag_chan", 64'(tag_channel), 64'd0);
    chk("rst_tag_frac", 64'(tag_frac), 64'd0);
    rst = 1'b0;
    wait_coarse(998);
    tick();
    chk("pre_wrap_coarse", 64'(cntr_coarse), 64'd999);
    chk("pre_wrap_utc", 64'(cntr_utc), 64'd0);
    tick();
    chk("wrap_coarse", 64'(cntr_coarse), 64'd0);
    chk("wrap_utc", 64'(cntr_utc), 64'd1);
    utc_load = 1'b1; utc_value = 32'h1234;
    tick();
    utc_load = 1'b0;
    chk("load_utc", 64'(cntr_utc), 64'h1234);
    chk("load_coarse", 64'(cntr_coarse), 64'd0);
    trig = 4'hF; frac = {12'h103, 12'h102, 12'h101, 12'h100};
    tick();
    trig = '0;
    chk("burst_lat_valid", 64'(tag_valid), 64'd0);
    tick();
    chk("burst_level", 64'(fifo_level), 64'd1);
    for (int c = 0; c < 4; c++) begin
      chk("burst_valid", 64'(tag_valid), 64'd1);
      chk("burst_chan", 64'(tag_channel), 64'(c));
      chk("burst_frac", 64'(tag_frac), 64'(12'h100 + c));
      tick();
    end
    chk("burst_empty", 64'(tag_valid), 64'd0);
    trig = 4'hF;
    tick();
    trig = '0;
    tick();
    chk("burst2_chan0", 64'(tag_channel), 64'd0);
    tick();
    chk("burst2_chan1", 64'(tag_channel), 64'd1);
    repeat (3) tick();
    chk("burst2_empty", 64'(tag_valid), 64'd0);
    wait_coarse(500);
    trig = 4'b0100; frac = '0; frac[2*FB +: FB] = 12'hABC;
    tick();
    trig = '0;
    chk("single_lat", 64'(tag_valid), 64'd0);
    tick();
    chk("single_valid", 64'(tag_valid), 64'd1);
    chk("single_chan", 64'(tag_channel), 64'd2);
    chk("single_coarse", 64'(tag_coarse), 64'd500);
    chk("single_frac", 64'(tag_frac), 64'hABC);
    chk("single_utc", 64'(tag_utc), 64'h1234);
    tick();
    chk("single_once", 64'(tag_valid), 64'd0);
    wait_coarse(999);
    trig = 4'b0001; frac = '0; frac[FB-1:0] = 12'h5A5;
    tick();
    trig = '0;
    chk("edge_live_utc", 64'(cntr_utc), 64'h1235);
    tick();
    chk("edge_valid", 64'(tag_valid), 64'd1);
    chk("edge_chan", 64'(tag_channel), 64'd0);
    chk("edge_coarse", 64'(tag_coarse), 64'd999);
    chk("edge_utc", 64'(tag_utc), 64'h1234);
    tick();
    tag_ready = 1'b0; trig = 4'b0010; frac = '0;
    for (int k = 1; k <= 17; k++) begin
      frac[FB +: FB] = 12'(k);
      tick();
    end
    chk("fill_level", 64'(fifo_level), 64'd16);
    chk("fill_no_ovf", 64'(overflow), 64'd0);
    frac[FB +: FB] = 12'd18;
    tick();
    trig = '0;
    chk("full_level", 64'(fifo_level), 64'd16);
    chk("full_ovf", 64'(overflow), 64'b0010);
    repeat (2) tick();
    chk("hold_level", 64'(fifo_level), 64'd16);
    chk("hold_frac", 64'(tag_frac), 64'd1);
    chk("hold_chan", 64'(tag_channel), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);
    tag_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      chk("drain_valid", 64'(tag_valid), 64'd1);
      chk("drain_frac", 64'(tag_frac), 64'(k));
      tick();
    end
    chk("drain_empty", 64'(tag_valid), 64'd0);
    chk("drain_level", 64'(fifo_level), 64'd0);
    enable = 4'b0111; trig = 4'b1000;
    repeat (3) tick();
    trig = '0;
    tick();
    chk("dis_valid", 64'(tag_valid), 64'd0);
    chk("dis_level", 64'(fifo_level), 64'd0);
    chk("dis_ovf", 64'(overflow), 64'd0);
    enable = 4'hF; tag_ready = 1'b0; trig = 4'hF;
    repeat (2) tick();
    trig = '0;
    chk("rr_ovf", 64'(overflow), 64'b1011);
    repeat (2) tick();
    tag_ready = 1'b1;
    tick();
    chk("mid_valid", 64'(tag_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 64'(tag_valid), 64'd0);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    chk("midrst_chan", 64'(tag_channel), 64'd0);
    repeat (2) tick();
    chk("midrst_stages_empty", 64'(tag_valid), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
